norm_writeback: RTL



---
 rtl/norm_writeback_if.sv | 35 +++
 rtl/norm_writeback.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/norm_writeback_if.sv
// Normalization-output stream and result-BRAM write port bundle for norm_writeback.
interface norm_writeback_if #(
  parameter int DESIGN_SIZE = 4,
  parameter int DWIDTH      = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int MASK_WIDTH  = DESIGN_SIZE
);
  logic                          enable_writeback;
  logic [ADDR_WIDTH-1:0]         start_addr;
  logic [ADDR_WIDTH-1:0]         address_stride;
  logic                          in_data_available;
  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data;
  logic [MASK_WIDTH-1:0]         validity_mask;
  logic                          done_norm;
  logic                          bram_en;
  logic [DESIGN_SIZE-1:0]        bram_we;
  logic [ADDR_WIDTH-1:0]         bram_addr;
  logic [DESIGN_SIZE*DWIDTH-1:0] bram_wdata;
  logic                          done_writeback;
  logic                          extra_col_err;

  // Upstream/controller side: drives the column stream, observes the BRAM port.
  modport master (
    output enable_writeback, start_addr, address_stride, in_data_available,
           inp_data, validity_mask, done_norm,
    input  bram_en, bram_we, bram_addr, bram_wdata, done_writeback, extra_col_err
  );

  // Writer side.
  modport slave (
    input  enable_writeback, start_addr, address_stride, in_data_available,
           inp_data, validity_mask, done_norm,
    output bram_en, bram_we, bram_addr, bram_wdata, done_writeback, extra_col_err
  );
endinterface

// File: rtl/norm_writeback.sv
// Writes one DESIGN_SIZE-column tile from the normalization stream into BRAM
// at strided addresses, masking lanes, and signals completion once the tile
// is written and the upstream done has been seen.
module norm_writeback #(
  parameter int DESIGN_SIZE = 4,
  parameter int DWIDTH      = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int MASK_WIDTH  = DESIGN_SIZE
) (
  input logic            clk,
  input logic            reset,
  norm_writeback_if.slave nw
);
  localparam int COL_W = DESIGN_SIZE * DWIDTH;
  localparam int CNT_W = $clog2(DESIGN_SIZE + 1);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_DONE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       col_cnt_q, col_cnt_d;
  logic [ADDR_WIDTH-1:0]  stride_q, stride_d;
  logic [ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;
  logic                   done_seen_q, done_seen_d;
  logic                   err_q, err_d;
  logic                   bram_en_q, bram_en_d;
  logic [DESIGN_SIZE-1:0] bram_we_q, bram_we_d;
  logic [ADDR_WIDTH-1:0]  bram_addr_q, bram_addr_d;
  logic [COL_W-1:0]       bram_wdata_q, bram_wdata_d;

  logic                   capture;
  logic [ADDR_WIDTH-1:0]  cap_addr;
  logic [CNT_W-1:0]       cnt_base;

  // Masked lanes are driven to zero so the BRAM never sees stale lane data.
  function automatic logic [COL_W-1:0] mask_lanes(input logic [COL_W-1:0] data,
                                                  input logic [MASK_WIDTH-1:0] mask);
    logic [COL_W-1:0] r;
    r = '0;
    for (int i = 0; i < DESIGN_SIZE; i++) begin
      if (mask[i]) r[i*DWIDTH +: DWIDTH] = data[i*DWIDTH +: DWIDTH];
    end
    return r;
  endfunction

  // Next-state, column capture and write-port computation.
  always_comb begin
    state_d      = state_q;
    col_cnt_d    = col_cnt_q;
    stride_d     = stride_q;
    next_addr_d  = next_addr_q;
    done_seen_d  = done_seen_q;
    err_d        = err_q;
    bram_en_d    = 1'b0;
    bram_we_d    = '0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    capture      = 1'b0;
    cap_addr     = next_addr_q;
    cnt_base     = col_cnt_q;

    if (!nw.enable_writeback) begin
      // Disable abandons everything and returns the port to its reset image.
      state_d      = IDLE;
      col_cnt_d    = '0;
      stride_d     = '0;
      next_addr_d  = '0;
      done_seen_d  = 1'b0;
      err_d        = 1'b0;
      bram_addr_d  = '0;
      bram_wdata_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          col_cnt_d   = '0;
          done_seen_d = 1'b0;
          err_d       = 1'b0;
          if (nw.in_data_available) begin
            capture     = 1'b1;
            cnt_base    = '0;
            stride_d    = nw.address_stride;
            cap_addr    = nw.start_addr;
            done_seen_d = nw.done_norm;
          end
        end
        WRITE: begin
          done_seen_d = done_seen_q | nw.done_norm;
          if (nw.in_data_available) capture = 1'b1;
        end
        WAIT_DONE: begin
          done_seen_d = done_seen_q | nw.done_norm;
          if (nw.done_norm) state_d = DONE;
          if (nw.in_data_available) err_d = 1'b1;
        end
        DONE: begin
          done_seen_d = done_seen_q | nw.done_norm;
          if (nw.in_data_available) err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (capture) begin
        bram_en_d    = 1'b1;
        bram_we_d    = nw.validity_mask;
        bram_addr_d  = cap_addr;
        bram_wdata_d = mask_lanes(nw.inp_data, nw.validity_mask);
        next_addr_d  = cap_addr + stride_d;
        col_cnt_d    = cnt_base + 1'b1;
        if (col_cnt_d == CNT_W'(DESIGN_SIZE)) begin
          state_d = done_seen_d ? DONE : WAIT_DONE;
        end else begin
          state_d = WRITE;
        end
      end
    end
  end

  // State, address generator and registered BRAM write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      col_cnt_q    <= '0;
      stride_q     <= '0;
      next_addr_q  <= '0;
      done_seen_q  <= 1'b0;
      err_q        <= 1'b0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= '0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      stride_q     <= stride_d;
      next_addr_q  <= next_addr_d;
      done_seen_q  <= done_seen_d;
      err_q        <= err_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
    end
  end

  assign nw.bram_en        = bram_en_q;
  assign nw.bram_we        = bram_we_q;
  assign nw.bram_addr      = bram_addr_q;
  assign nw.bram_wdata     = bram_wdata_q;
  assign nw.done_writeback = (state_q == DONE);
  assign nw.extra_col_err  = err_q;
endmodule
